// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE sequencing controller.
package pe_ctrl_pkg;

  localparam int ADDR_W = 3;

  localparam logic RW_READ      = 1'b0;
  localparam logic RW_WRITE     = 1'b1;
  localparam logic SEL_PRODUCT  = 1'b0;
  localparam logic SEL_PSUM_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_CHAIN,
    ST_OUT
  } pe_state_t;

endpackage

// File: rtl/pe_seq_controller_if.sv
// Scheduler handshake plus PE control strobes; master = scheduler side, slave = controller.
interface pe_seq_controller_if;
  import pe_ctrl_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] cfg_taps;
  logic              cfg_chain;
  logic              busy;
  logic              data_req;
  logic              done;
  logic              enable;
  logic              rw_mode_w;
  logic              rw_mode_i;
  logic [ADDR_W-1:0] counter_1;
  logic [ADDR_W-1:0] addr_i;
  logic              rw_mode_psum;
  logic              addr_psum;
  logic              psum_clr;
  logic              sign_sel;
  logic              enable_active;

  modport master (
    output start, cfg_taps, cfg_chain,
    input  busy, data_req, done, enable, rw_mode_w, rw_mode_i, counter_1, addr_i,
           rw_mode_psum, addr_psum, psum_clr, sign_sel, enable_active
  );

  modport slave (
    input  start, cfg_taps, cfg_chain,
    output busy, data_req, done, enable, rw_mode_w, rw_mode_i, counter_1, addr_i,
           rw_mode_psum, addr_psum, psum_clr, sign_sel, enable_active
  );

endinterface

// File: rtl/pe_seq_controller_tap_counter.sv
// Loadable down-counter with terminal flag, shared by the LOAD, MAC and DRAIN phases.
module tap_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/pe_seq_controller.sv
// One-window sequencer for a PE slot: clear, load taps, MAC, drain, optional chain add, present.
module pe_seq_controller
  import pe_ctrl_pkg::*;
#(
  parameter int MAX_TAPS = 8,
  parameter int PIPE_LAT = 2
) (
  input logic                clk,
  input logic                rst_n,
  pe_seq_controller_if.slave bus
);

  localparam logic [ADDR_W-1:0] TAPS_CAP   = ADDR_W'(MAX_TAPS - 1);
  localparam logic [ADDR_W-1:0] DRAIN_LOAD = ADDR_W'(PIPE_LAT - 1);

  pe_state_t         state_q, state_d;
  logic [ADDR_W-1:0] taps_m1_q;
  logic              chain_q;
  logic              addr_psum_q;
  logic              accept;
  logic              cnt_load, cnt_dec, cnt_last;
  logic [ADDR_W-1:0] cnt_val, cnt;
  logic [ADDR_W-1:0] idx;
  logic [PIPE_LAT-1:0] mac_vld_p;
  logic [PIPE_LAT:0]   mac_vld_shift;

  tap_counter #(.W(ADDR_W)) u_tap_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // Counter runs down, so the ascending tap index is its distance from the top.
  assign idx = taps_m1_q - cnt;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = taps_m1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_load = 1'b1;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          state_d  = ST_MAC;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_MAC: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = DRAIN_LOAD;
          state_d  = ST_DRAIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_last)
          state_d = chain_q ? ST_CHAIN : ST_OUT;
        else
          cnt_dec = 1'b1;
      end
      ST_CHAIN: state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_m1_q   <= '0;
      chain_q     <= 1'b0;
      addr_psum_q <= 1'b0;
    end else if (accept) begin
      taps_m1_q   <= (bus.cfg_taps > TAPS_CAP) ? TAPS_CAP : bus.cfg_taps;
      chain_q     <= bus.cfg_chain;
      addr_psum_q <= ~addr_psum_q;
    end
  end

  // --- read issue -> product valid at adder, PIPE_LAT cycles later ---
  assign mac_vld_shift = {mac_vld_p, (state_q == ST_MAC)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mac_vld_p <= '0;
    else
      mac_vld_p <= mac_vld_shift[PIPE_LAT-1:0];
  end

  always_comb begin
    bus.busy          = (state_q != ST_IDLE);
    bus.enable        = (state_q != ST_IDLE);
    bus.data_req      = 1'b0;
    bus.done          = 1'b0;
    bus.rw_mode_w     = RW_READ;
    bus.rw_mode_i     = RW_READ;
    bus.counter_1     = '0;
    bus.addr_i        = '0;
    bus.rw_mode_psum  = mac_vld_p[PIPE_LAT-1] ? RW_WRITE : RW_READ;
    bus.addr_psum     = addr_psum_q;
    bus.psum_clr      = 1'b0;
    bus.sign_sel      = SEL_PRODUCT;
    bus.enable_active = 1'b0;
    unique case (state_q)
      ST_CLEAR: bus.psum_clr = 1'b1;
      ST_LOAD: begin
        bus.data_req  = 1'b1;
        bus.rw_mode_w = RW_WRITE;
        bus.rw_mode_i = RW_WRITE;
        bus.counter_1 = idx;
        bus.addr_i    = idx;
      end
      ST_MAC: begin
        bus.counter_1 = idx;
        bus.addr_i    = idx;
      end
      ST_CHAIN: begin
        bus.sign_sel     = SEL_PSUM_SUB;
        bus.rw_mode_psum = RW_WRITE;
      end
      ST_OUT: begin
        bus.done          = 1'b1;
        bus.enable_active = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
